// File: rtl/bubble_pkg.sv
// Shared BUBBLE core constants: register file geometry and
// architectural register indices the decoder refers to.
package bubble_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam int ZERO_IDX = 0;
  localparam int RA_IDX   = 1;
  localparam int SP_IDX   = 2;
  localparam int GP_IDX   = 3;
  localparam int TP_IDX   = 4;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

endpackage

// File: rtl/bubble_scoreboard.sv
// Per-register busy flags: decode reserves, writeback releases.
// Reservation beats release on the same index (younger producer).
module bubble_scoreboard
  import bubble_pkg::*;
#(
  parameter int NUM_REGS = bubble_pkg::NUM_REGS,
  parameter int ADDR_W   = bubble_pkg::REG_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[ZERO_IDX] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/bubble_regfile_mp.sv
// Multi-port register file with busy scoreboard for BUBBLE.
// Define REGFILE_WR_BYPASS_EN for same-cycle write-to-read bypass.
module bubble_regfile_mp
  import bubble_pkg::*;
#(
  parameter int DATA_W   = bubble_pkg::DATA_W,
  parameter int NUM_REGS = bubble_pkg::NUM_REGS,
  parameter int ADDR_W   = bubble_pkg::REG_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     any_busy
);

  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_ok;

  assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == ZA);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  bubble_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .busy     (busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              rbsy;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rdat = mem_q[ra];
      rbsy = busy[ra];
`ifdef REGFILE_WR_BYPASS_EN
      if (wr_en && wr_addr == ra) begin
        rdat = wr_data;
        rbsy = busy[ra] && rsv_en && rsv_addr == ra;
      end
`endif
      // Hardwired zero overrides any bypass
      if (ZERO_REG != 0 && ra == ZA) begin
        rdat = '0;
        rbsy = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rdat;
    assign rd_busy[k] = rbsy;
  end

  assign any_busy = |busy;

endmodule

// File: tb/tb_bubble_regfile_mp.sv
// Scoreboard-driven bench for bubble_regfile_mp (2 read ports).
// Expectations follow REGFILE_WR_BYPASS_EN when it is defined.
module tb_bubble_regfile_mp;

`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        any_busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        r;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [4:0]  ra;
    logic [4:0]  a1;
    logic [4:0]  a0;
    logic        chk;
    logic [31:0] e1;
    logic [31:0] e0;
    logic [1:0]  eb;
    logic        eab;
  } step_t;

  step_t eq[$];

  always #5 clk = ~clk;

  bubble_regfile_mp dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .any_busy (any_busy)
  );

  function automatic step_t mk(
    int r, int we, int wa, int wd, int rv, int ra,
    int a1, int a0, int chk, int e1, int e0, int eb, int eab);
    step_t s;
    s.r   = (r != 0);
    s.we  = (we != 0);
    s.wa  = 5'(wa);
    s.wd  = wd;
    s.rv  = (rv != 0);
    s.ra  = 5'(ra);
    s.a1  = 5'(a1);
    s.a0  = 5'(a0);
    s.chk = (chk != 0);
    s.e1  = e1;
    s.e0  = e0;
    s.eb  = 2'(eb);
    s.eab = (eab != 0);
    return s;
  endfunction

  task automatic apply(input step_t s);
    @(posedge clk);
    #1;
    rst      = s.r;
    wr_en    = s.we;
    wr_addr  = s.wa;
    wr_data  = s.wd;
    rsv_en   = s.rv;
    rsv_addr = s.ra;
    rd_addr  = {s.a1, s.a0};
  endtask

  task automatic test_reset();
    step_t st[$];
    step_t e;
    st.push_back(mk(1, 1, 7, 55, 1, 7, 7, 7, 0, 0, 0, 0, 0));
    for (int i = 0; i < 32; i++)
      st.push_back(mk(0, 0, 0, 0, 0, 0, i, i, 1, 0, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) eq.push_back(st[i]);
      @(negedge clk);
      if (st[i].chk) begin
        e = eq.pop_front();
        vectors++;
        if ({rd_data, rd_busy, any_busy} !==
            {e.e1, e.e0, e.eb, e.eab}) begin
          miscompares++;
          $display("FAIL reset[%0d]: got %h/%h b=%b a=%b want %h/%h b=%b a=%b",
                   i, rd_data[63:32], rd_data[31:0], rd_busy, any_busy,
                   e.e1, e.e0, e.eb, e.eab);
        end
      end
    end
  endtask

  task automatic test_write();
    step_t st[$];
    step_t e;
    st.push_back(mk(0, 1, 1, 3216, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 3216, 3216, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 1, 3216, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) eq.push_back(st[i]);
      @(negedge clk);
      if (st[i].chk) begin
        e = eq.pop_front();
        vectors++;
        if ({rd_data, rd_busy, any_busy} !==
            {e.e1, e.e0, e.eb, e.eab}) begin
          miscompares++;
          $display("FAIL write[%0d]: got %h/%h b=%b a=%b want %h/%h b=%b a=%b",
                   i, rd_data[63:32], rd_data[31:0], rd_busy, any_busy,
                   e.e1, e.e0, e.eb, e.eab);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    step_t st[$];
    step_t e;
    st.push_back(mk(0, 1, 0, 32'hDEADBEEF, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) eq.push_back(st[i]);
      @(negedge clk);
      if (st[i].chk) begin
        e = eq.pop_front();
        vectors++;
        if ({rd_data, rd_busy, any_busy} !==
            {e.e1, e.e0, e.eb, e.eab}) begin
          miscompares++;
          $display("FAIL zero[%0d]: got %h/%h b=%b a=%b want %h/%h b=%b a=%b",
                   i, rd_data[63:32], rd_data[31:0], rd_busy, any_busy,
                   e.e1, e.e0, e.eb, e.eab);
        end
      end
    end
  endtask

  task automatic test_reserve();
    step_t st[$];
    step_t e;
    int    bd;
    int    bb;
    bd = BYP ? 7 : 0;
    bb = BYP ? 0 : 3;
    st.push_back(mk(0, 0, 0, 0, 1, 5, 5, 5, 1, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 5, 7, 0, 0, 5, 5, 1, bd, bd, bb, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 5, 5, 1, 7, 7, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) eq.push_back(st[i]);
      @(negedge clk);
      if (st[i].chk) begin
        e = eq.pop_front();
        vectors++;
        if ({rd_data, rd_busy, any_busy} !==
            {e.e1, e.e0, e.eb, e.eab}) begin
          miscompares++;
          $display("FAIL reserve[%0d]: got %h/%h b=%b a=%b want %h/%h b=%b a=%b",
                   i, rd_data[63:32], rd_data[31:0], rd_busy, any_busy,
                   e.e1, e.e0, e.eb, e.eab);
        end
      end
    end
  endtask

  task automatic test_sb_edges();
    step_t st[$];
    step_t e;
    int    d42;
    int    d43;
    int    d11;
    int    bb;
    d42 = BYP ? 42 : 0;
    d43 = BYP ? 43 : 42;
    d11 = BYP ? 11 : 0;
    bb  = BYP ? 0 : 3;
    st.push_back(mk(0, 1, 9, 42, 1, 9, 9, 9, 1, d42, d42, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 9, 9, 1, 42, 42, 3, 1));
    st.push_back(mk(0, 0, 0, 0, 1, 9, 9, 9, 1, 42, 42, 3, 1));
    st.push_back(mk(0, 1, 9, 43, 0, 0, 9, 9, 1, d43, d43, bb, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 9, 9, 1, 43, 43, 0, 0));
    st.push_back(mk(0, 1, 10, 11, 0, 0, 10, 10, 1, d11, d11, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 10, 9, 1, 11, 43, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) eq.push_back(st[i]);
      @(negedge clk);
      if (st[i].chk) begin
        e = eq.pop_front();
        vectors++;
        if ({rd_data, rd_busy, any_busy} !==
            {e.e1, e.e0, e.eb, e.eab}) begin
          miscompares++;
          $display("FAIL sb_edge[%0d]: got %h/%h b=%b a=%b want %h/%h b=%b a=%b",
                   i, rd_data[63:32], rd_data[31:0], rd_busy, any_busy,
                   e.e1, e.e0, e.eb, e.eab);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t st[$];
    step_t e;
    st.push_back(mk(0, 0, 0, 0, 1, 3, 4, 3, 1, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 1, 4, 4, 3, 1, 0, 0, 1, 1));
    st.push_back(mk(1, 1, 11, 99, 1, 12, 4, 3, 1, 0, 0, 3, 1));
    for (int i = 0; i < 32; i++)
      st.push_back(mk(0, 0, 0, 0, 0, 0, i, i, 1, 0, 0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) eq.push_back(st[i]);
      @(negedge clk);
      if (st[i].chk) begin
        e = eq.pop_front();
        vectors++;
        if ({rd_data, rd_busy, any_busy} !==
            {e.e1, e.e0, e.eb, e.eab}) begin
          miscompares++;
          $display("FAIL reset_mid[%0d]: got %h/%h b=%b a=%b want %h/%h b=%b a=%b",
                   i, rd_data[63:32], rd_data[31:0], rd_busy, any_busy,
                   e.e1, e.e0, e.eb, e.eab);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t st[$];
    step_t e;
    int    v[4];
    for (int j = 0; j < 4; j++) v[j] = int'($urandom);
    st.push_back(mk(0, 1, 12, v[0], 0, 0, 12, 12, 0, 0, 0, 0, 0));
    st.push_back(mk(0, 1, 13, v[1], 0, 0, 12, 12, 1, v[0], v[0], 0, 0));
    st.push_back(mk(0, 1, 14, v[2], 0, 0, 13, 12, 1, v[1], v[0], 0, 0));
    st.push_back(mk(0, 1, 15, v[3], 0, 0, 14, 13, 1, v[2], v[1], 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 15, 14, 1, v[3], v[2], 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) eq.push_back(st[i]);
      @(negedge clk);
      if (st[i].chk) begin
        e = eq.pop_front();
        vectors++;
        if ({rd_data, rd_busy, any_busy} !==
            {e.e1, e.e0, e.eb, e.eab}) begin
          miscompares++;
          $display("FAIL b2b[%0d]: got %h/%h b=%b a=%b want %h/%h b=%b a=%b",
                   i, rd_data[63:32], rd_data[31:0], rd_busy, any_busy,
                   e.e1, e.e0, e.eb, e.eab);
        end
      end
    end
  endtask

  task automatic test_bypass();
    step_t st[$];
    step_t e;
    int    d;
    d = BYP ? 100 : 0;
    st.push_back(mk(0, 1, 6, 100, 0, 0, 6, 0, 1, d, 0, 0, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 6, 6, 1, 100, 100, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      if (st[i].chk) eq.push_back(st[i]);
      @(negedge clk);
      if (st[i].chk) begin
        e = eq.pop_front();
        vectors++;
        if ({rd_data, rd_busy, any_busy} !==
            {e.e1, e.e0, e.eb, e.eab}) begin
          miscompares++;
          $display("FAIL bypass[%0d]: got %h/%h b=%b a=%b want %h/%h b=%b a=%b",
                   i, rd_data[63:32], rd_data[31:0], rd_busy, any_busy,
                   e.e1, e.e0, e.eb, e.eab);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    rd_addr  = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_write();
    test_zero_reg();
    test_reserve();
    test_sb_edges();
    test_reset_mid();
    test_back_to_back();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bubble_regfile_mp.md
Name: bubble_regfile_mp

Overview:
Parametrised multi-port register file for the BUBBLE processor core. It replaces the single-port mode-select register bank.
- N combinational read ports, one clocked write port.
- Optional hardwired zero register.
- Per-register busy scoreboard, so the pipeline can stall on operands still owed by an in-flight producer.
- Sits between decode (reads, reservations) and writeback (writes, busy release).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of two, >= 2)
ADDR_W, 5, register index width; must equal clog2(NUM_REGS)
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never busy

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read indices, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, port k at bits [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  busy flag of the register addressed by each read port
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback index
wr_data  in  DATA_W  writeback value
rsv_en  in  1  decode reserves a destination register
rsv_addr  in  ADDR_W  index being reserved
any_busy  out  1  OR of all busy bits (drain detect)

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
  - No other clock or reset exists.
- Reset: on a rising edge with rst=1, all registers clear to 0 and all busy bits clear to 0.
  - After reset, rd_data=0, rd_busy=0 and any_busy=0 for every address.
  - rst overrides wr_en and rsv_en in the same cycle.
  - rst asserted mid-operation discards all pending reservations. No write lands that cycle.
- Reads:
  - Purely combinational from current array state; zero-cycle latency.
  - Ports are independent; any ports may address the same register.
- Write:
  - When wr_en=1, reg[wr_addr] <= wr_data at the rising edge.
  - The new value is visible on reads the cycle after. Without the optional feature, a same-cycle read returns the old value.
- Zero register (ZERO_REG=1):
  - Writes to index 0 are dropped.
  - rd_data for index 0 is always 0.
  - rsv_en to index 0 is ignored, so busy[0] is constantly 0.
- Scoreboard, per register i, next-state priority:
  1. rst -> 0
  2. rsv_en && rsv_addr==i -> 1
  3. wr_en && wr_addr==i -> 0
  4. hold
- Scoreboard consequences:
  - Simultaneous reserve and write to the same index leaves busy=1, because the reservation belongs to a younger producer. The data write still lands.
  - Reserving an already-busy register keeps it at 1; there is no counting.
  - A write to a non-busy register is legal, updates data, and leaves busy at 0.
- rd_busy[k] = busy[rd_addr[k]], registered state only; any_busy = |busy.
- Out-of-range addresses cannot occur since NUM_REGS = 2^ADDR_W.

Optional Feature:
Macro REGFILE_WR_BYPASS_EN.
- Defined:
  - When wr_en=1 and wr_addr matches rd_addr[k], rd_data[k]=wr_data in the same cycle.
  - rd_busy[k] is forced to 0 unless rsv_en also targets that index this cycle.
  - The ZERO_REG rule still wins for index 0.
- Undefined: reads see only registered state, as described above.
- Array and scoreboard update rules are identical in both builds.

Decomposition:
- Shared package bubble_pkg holds:
  - DATA_W=32, REG_ADDR_W=5, NUM_REGS=32
  - ZERO_IDX=0
  - localparams for register indices the decoder references
- Natural sub-module bubble_scoreboard contains:
  - NUM_REGS busy flops with the priority update above
  - ports clk, rst, rsv_en, rsv_addr, clr_en, clr_addr, busy vector
- The top instantiates it and does the per-port busy muxing.

Test Plan:
1. Reset, then read all 32 indices on both ports -> rd_data=0, rd_busy=0, any_busy=0.
2. Write 32'd3216 to r1 with wr_en=1, read r1 the next cycle on port 0 and port 1 -> both return 3216. Read r2 -> 0.
3. Write 32'hDEADBEEF to r0 with ZERO_REG=1 and try to reserve r0 -> rd_data(r0)=0, rd_busy=0.
4. Reserve r5, then read r5 -> rd_busy=1, any_busy=1. Next cycle write r5=7 -> the cycle after, rd_busy=0 and rd_data=7.
5. Scoreboard edge cases:
   - Same-cycle rsv_en and wr_en to r9 with data 42 -> next cycle rd_data=42, rd_busy=1.
   - Reserve r3, r4, then assert rst -> all busy 0, all data 0.
6. With REGFILE_WR_BYPASS_EN, write r6=100 while port 1 reads r6 -> rd_data=100 and rd_busy=0 in the same cycle. Without the macro -> old value (0) in that cycle.
